// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module      : id_ex_stage_if
// Description : ID-side inputs and EX-side outputs of the ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 8
);
  logic              id_valid;
  logic [6:0]        id_opcode;
  logic              id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
  logic              id_alu_src, id_reg_write;
  logic [1:0]        id_alu_op;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]        id_funct;
  logic              ex_flush;

  logic              ex_valid;
  logic              ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic              ex_alu_src, ex_reg_write;
  logic [1:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]        ex_funct;
  logic              stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_opcode, id_branch, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op,
           id_rd1, id_rd2, id_imm, id_pc, id_rs1, id_rs2, id_rd, id_funct,
           ex_flush,
    input  ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_alu_op,
           ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct,
           stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_branch, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op,
           id_rd1, id_rd2, id_imm, id_pc, id_rs1, id_rs2, id_rd, id_funct,
           ex_flush,
    output ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_alu_op,
           ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct,
           stall, bubble_cnt
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall and EX flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  id_ex_stage_if.slave  bus
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        funct;
  } ex_regs_t;

  ex_regs_t         ex_q, ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             uses_rs1, uses_rs2;
  logic             hazard, load_bubble;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (bus.id_opcode)
      OPC_R, OPC_STORE, OPC_BR: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Hazard looks only at registered EX state and live ID inputs.
  assign hazard = ex_q.valid & ex_q.mem_read & bus.id_valid & (ex_q.rd != '0) &
                  (((ex_q.rd == bus.id_rs1) & uses_rs1) |
                   ((ex_q.rd == bus.id_rs2) & uses_rs2));

  assign load_bubble = bus.ex_flush | hazard;
  assign bus.stall   = hazard & ~bus.ex_flush;

  always_comb begin
    ex_d = '0;
    if (!load_bubble) begin
      ex_d.valid = bus.id_valid;
      ex_d.rd1   = bus.id_rd1;
      ex_d.rd2   = bus.id_rd2;
      ex_d.imm   = bus.id_imm;
      ex_d.pc    = bus.id_pc;
      ex_d.rs1   = bus.id_rs1;
      ex_d.rs2   = bus.id_rs2;
      ex_d.rd    = bus.id_rd;
      ex_d.funct = bus.id_funct;
      if (bus.id_valid) begin
        ex_d.branch     = bus.id_branch;
        ex_d.mem_read   = bus.id_mem_read;
        ex_d.mem_to_reg = bus.id_mem_to_reg;
        ex_d.mem_write  = bus.id_mem_write;
        ex_d.alu_src    = bus.id_alu_src;
        ex_d.reg_write  = bus.id_reg_write;
        ex_d.alu_op     = bus.id_alu_op;
      end
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_rd1        = ex_q.rd1;
  assign bus.ex_rd2        = ex_q.rd2;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_funct      = ex_q.funct;
  assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(8), .REG_AW(5), .CNT_W(8)) bus ();

  id_ex_stage #(.DATA_W(8), .REG_AW(5), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected EX state; control packed as {branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,alu_op}
  bit       m_valid;
  bit [7:0] m_ctrl;
  bit [7:0] m_rd1, m_rd2, m_imm, m_pc;
  bit [4:0] m_rs1, m_rs2, m_rd;
  bit [3:0] m_funct;
  int       m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit model_hazard();
    if (!(m_valid && m_ctrl[6] && bus.id_valid && m_rd != 0)) return 1'b0;
    return (m_rd == bus.id_rs1 && reads_rs1(bus.id_opcode)) ||
           (m_rd == bus.id_rs2 && reads_rs2(bus.id_opcode));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (bus.ex_flush || model_hazard()) begin
      int c;
      c = m_cnt;
      model_reset();
      m_cnt = (c < 255) ? c + 1 : 255;
    end else begin
      m_valid = bus.id_valid;
      m_ctrl  = bus.id_valid ? {bus.id_branch, bus.id_mem_read, bus.id_mem_to_reg,
                                bus.id_mem_write, bus.id_alu_src, bus.id_reg_write,
                                bus.id_alu_op} : 8'h00;
      m_rd1 = bus.id_rd1; m_rd2 = bus.id_rd2; m_imm = bus.id_imm; m_pc = bus.id_pc;
      m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2; m_rd = bus.id_rd; m_funct = bus.id_funct;
    end
  endtask

  function automatic logic [63:0] dut_pack();
    return {4'h0, bus.ex_valid, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg,
            bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op,
            bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_pc,
            bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct};
  endfunction

  function automatic logic [63:0] model_pack();
    return {4'h0, m_valid, m_ctrl, m_rd1, m_rd2, m_imm, m_pc, m_rs1, m_rs2, m_rd, m_funct};
  endfunction

  task automatic set_id(input bit v, input bit [6:0] op, input bit [7:0] ctrl,
                        input bit [7:0] rd1, input bit [7:0] rd2, input bit [7:0] imm,
                        input bit [7:0] pc, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit [3:0] funct, input bit flush);
    bus.id_valid      = v;
    bus.id_opcode     = op;
    bus.id_branch     = ctrl[7];
    bus.id_mem_read   = ctrl[6];
    bus.id_mem_to_reg = ctrl[5];
    bus.id_mem_write  = ctrl[4];
    bus.id_alu_src    = ctrl[3];
    bus.id_reg_write  = ctrl[2];
    bus.id_alu_op     = ctrl[1:0];
    bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm; bus.id_pc = pc;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd; bus.id_funct = funct;
    bus.ex_flush = flush;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle(input string tag);
    #1;
    chk({tag, ".stall"}, 64'(bus.stall), 64'(model_hazard() && !bus.ex_flush));
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".regs"}, dut_pack(), model_pack());
    chk({tag, ".cnt"}, 64'(bus.bubble_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  localparam bit [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_SD = 7'b0100011;
  localparam bit [6:0] OP_BEQ = 7'b1100011, OP_AUIPC = 7'b0010111, OP_ADDI = 7'b0010011;
  localparam bit [7:0] C_R = 8'b0000_0110, C_LD = 8'b0110_1100;
  localparam bit [7:0] C_SD = 8'b0001_1000, C_BEQ = 8'b1000_0001;

  initial begin
    bit [6:0] ops [6];
    ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD;
    ops[3] = OP_BEQ; ops[4] = OP_AUIPC; ops[5] = OP_ADDI;

    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("reset.regs", dut_pack(), 64'h0);
    chk("reset.cnt", 64'(bus.bubble_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through R-type
    set_id(1, OP_R, C_R, 8'h12, 8'h34, 8'h00, 8'h40, 5'd1, 5'd2, 5'd5, 4'h0, 0);
    cycle("pass");
    chk("pass.rd1", 64'(bus.ex_rd1), 64'h12);
    chk("pass.valid", 64'(bus.ex_valid), 64'h1);

    // Load-use: ld x3 then R-type reading x3 through rs2
    set_id(1, OP_LD, C_LD, 8'h00, 8'h00, 8'h04, 8'h44, 5'd1, 5'd0, 5'd3, 4'h3, 0);
    cycle("ld");
    set_id(1, OP_R, C_R, 8'h21, 8'h43, 8'h00, 8'h48, 5'd4, 5'd3, 5'd6, 4'h8, 0);
    #1;
    chk("lu.stall_hi", 64'(bus.stall), 64'h1);
    cycle("lu.bubble");
    chk("lu.bubble_cnt", 64'(bus.bubble_cnt), 64'h1);
    cycle("lu.capture");
    chk("lu.captured_valid", 64'(bus.ex_valid), 64'h1);

    // No false hazards
    set_id(1, OP_LD, C_LD, 0, 0, 8'h08, 8'h4C, 5'd2, 5'd0, 5'd0, 4'h3, 0);
    cycle("ldx0");
    set_id(1, OP_R, C_R, 1, 2, 0, 8'h50, 5'd0, 5'd0, 5'd7, 4'h0, 0);
    cycle("ldx0.use");
    set_id(1, OP_LD, C_LD, 0, 0, 8'h0C, 8'h54, 5'd2, 5'd0, 5'd3, 4'h3, 0);
    cycle("ldx3");
    set_id(1, OP_AUIPC, 8'b0000_1100, 0, 0, 8'h10, 8'h58, 5'd3, 5'd3, 5'd8, 4'h0, 0);
    cycle("auipc.use");
    set_id(1, OP_SD, C_SD, 0, 0, 8'h10, 8'h5C, 5'd2, 5'd1, 5'd3, 4'h3, 0);
    cycle("sd");
    set_id(1, OP_R, C_R, 0, 0, 0, 8'h60, 5'd3, 5'd3, 5'd9, 4'h0, 0);
    cycle("sd.use");

    // Flush overriding a hazard, then flush alone on a beq
    set_id(1, OP_LD, C_LD, 0, 0, 8'h14, 8'h64, 5'd2, 5'd0, 5'd3, 4'h3, 0);
    cycle("fl.ld");
    set_id(1, OP_R, C_R, 0, 0, 0, 8'h68, 5'd3, 5'd1, 5'd9, 4'h0, 1);
    cycle("fl.hazard");
    set_id(1, OP_BEQ, C_BEQ, 8'h05, 8'h05, 8'hF8, 8'h6C, 5'd1, 5'd2, 5'd0, 4'h0, 1);
    cycle("fl.beq");
    chk("fl.branch", 64'(bus.ex_branch), 64'h0);
    chk("fl.valid", 64'(bus.ex_valid), 64'h0);

    // Randomized traffic; small register range so hazards are frequent
    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(0, 3) != 0, ops[$urandom_range(0, 5)], 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 4'($urandom), $urandom_range(0, 7) == 0);
      cycle("rand");
    end

    // Saturation
    for (int i = 0; i < 300; i++) begin
      set_id(1, OP_R, C_R, 8'($urandom), 0, 0, 8'(i), 5'd1, 5'd2, 5'd3, 4'h0, 1);
      cycle("sat");
    end
    chk("sat.ff", 64'(bus.bubble_cnt), 64'hFF);

    // Reset asserted mid-stall
    set_id(1, OP_LD, C_LD, 0, 0, 8'h1C, 8'h70, 5'd2, 5'd0, 5'd4, 4'h3, 0);
    cycle("rs.ld");
    set_id(1, OP_R, C_R, 0, 0, 0, 8'h74, 5'd4, 5'd1, 5'd9, 4'h0, 0);
    #1;
    chk("rs.stall_hi", 64'(bus.stall), 64'h1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rs.regs", dut_pack(), model_pack());
    chk("rs.cnt", 64'(bus.bubble_cnt), 64'h0);
    chk("rs.stall_lo", 64'(bus.stall), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1, OP_R, C_R, 8'h12, 8'h34, 0, 8'h78, 5'd4, 5'd1, 5'd5, 4'h0, 0);
    cycle("rs.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 8-bit RISC-V pipeline.
- Sits directly downstream of the instruction-decode control unit. Registers its control outputs together with operands and register indices for the EX stage.
- Contains load-use hazard detection: stalls PC and IF/ID and inserts a bubble.
- Honours a branch flush from EX.

Parameters:
- DATA_W, 8, width of register-file operands, immediate and PC
- REG_AW, 5, register index width
- CNT_W, 8, width of bubble performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  7  opcode of ID instruction
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decoded control
- id_alu_op  in  2  decoded ALU op
- id_rd1, id_rd2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc  in  DATA_W  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices
- id_funct  in  4  {funct7[5], funct3}
- ex_flush  in  1  branch taken in EX; kill ID instruction
- ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered
- ex_alu_op  out  2  registered
- ex_rd1, ex_rd2, ex_imm, ex_pc  out  DATA_W  registered
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered
- ex_funct  out  4  registered
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including ex_valid and bubble_cnt. The stage holds a bubble.
- Hazard detect (combinational):
  - Condition: hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & ((ex_rd == id_rs1 & uses_rs1) | (ex_rd == id_rs2 & uses_rs2)).
  - uses_rs1 = 1 for opcodes 0110011, 0000011, 0100011, 1100011.
  - uses_rs2 = 1 for opcodes 0110011, 0100011, 1100011.
  - Any other opcode uses neither register.
- stall = hazard & ~ex_flush. A flush overrides the stall because the ID instruction is being killed.
- Each rising edge, priority is flush > hazard > capture:
  - ex_flush = 1: load a bubble.
  - else hazard = 1: load a bubble. ID contents stay upstream because stall is high, and the instruction is re-presented next cycle.
  - else: capture all id_* into ex_*, with ex_valid = id_valid.
- Bubble content: ex_valid, all control bits and ex_alu_op are 0. ex_mem_to_reg is 0, never X.
- Bubble datapath: ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd and ex_funct are 0, so the bubble cannot alias any forwarding compare.
- Capture with id_valid = 0: all control bits are forced to 0. Datapath fields are captured as-is.
- Latency is 1 cycle from ID inputs to ex_* outputs. A load-use hazard costs exactly 1 bubble. The stall is high for one cycle only, because the load has left EX after the bubble.
- bubble_cnt increments by 1 on every edge that loads a bubble due to flush or hazard. It saturates at all-ones and does not wrap. Reset-only bubbles are not counted.
- Flush and hazard in the same cycle count as one bubble, and stall = 0.
- Reset asserted mid-stall: outputs clear immediately and stall drops, since ex_valid = 0.
- No combinational path exists from id_* to ex_*. stall depends only on the current ex_* registers and the id_* inputs.

Test Plan:
- Reset: rst_n = 0 mid-cycle with ex_* nonzero → all ex_* and bubble_cnt = 0 immediately, without waiting for a clock edge.
- Pass-through: R-type, opcode 0110011, rd1 = 8'h12, rd2 = 8'h34, rd = 5, reg_write = 1, alu_op = 10 → next edge ex_* match, ex_valid = 1, stall = 0.
- Load-use stall: ld x3 in EX (mem_read = 1, ex_rd = 3) with R-type rs2 = 3 in ID → stall = 1, next edge bubble with all control 0 and bubble_cnt = 1. On the following edge the R-type is captured and stall = 0.
- No false hazard: ld x0 in EX with rs1 = 0 in ID → stall = 0. ld x3 in EX with ID opcode 0010111 (unknown) and rs1 = 3 → stall = 0. sd in EX with ex_rd = 3 → stall = 0.
- Flush priority: hazard condition and ex_flush = 1 together → stall = 0, one bubble, bubble_cnt increments by 1. Flush alone with valid beq in ID → ex_branch = 0, ex_valid = 0.
- Saturation: force 300 consecutive flushes → bubble_cnt stops at 8'hFF.
